// File: rtl/xps2_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver peripheral.
package xps2_rx_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DATA_VALID_BIT = 8;

    // STATUS register bit positions
    localparam int unsigned ST_PERR    = 0;
    localparam int unsigned ST_FERR    = 1;
    localparam int unsigned ST_OVR     = 2;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_e;

endpackage

// File: rtl/xps2_rx_fifo.sv
// Small synchronous FIFO holding received scan-code bytes; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module xps2_rx_fifo #(
    parameter int unsigned DEPTH_LOG = 2,
    parameter int unsigned W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         wdata,
    output logic [W-1:0]         head_c,
    output logic                 empty_c,
    output logic                 full_c,
    output logic                 drop_c,
    output logic [DEPTH_LOG:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned CNT_W = DEPTH_LOG + 1;

    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 wr_en;
    logic                 rd_en;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));
    assign rd_en   = pop && !empty_c;
    assign wr_en   = push && (!full_c || rd_en);
    assign drop_c  = push && !wr_en;
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
            if (rd_en) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Storage needs no reset: the head is masked by the consumer while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/xps2_rx.sv
// PS/2 device-to-host receiver: sync/filter the lines, deserialise 11-bit frames,
// buffer bytes in a FIFO and expose DATA/STATUS registers to picoVersat.
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC    = 15000,
    parameter int unsigned FIFO_DEPTH_LOG = 2,
    parameter bit          PARITY_DROP    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BCNT_W = $clog2(BYTE_W);

    logic [1:0]        clk_sync, dat_sync;
    logic              clk_s, data_s;
    logic [FCNT_W-1:0] fcnt;
    logic              filt, flip_c, fall;

    rx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              acc_q, acc_d, perr_q, perr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              push_q, push_d, ferr_q, ferr_d;

    logic              perr_flag, ferr_flag, ovr_flag;
    logic [2:0]        clr_c;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_drop;
    logic [BYTE_W-1:0] fifo_head;
    logic [FIFO_DEPTH_LOG:0] fifo_count;
    logic              unused_data_in;

    assign clk_s  = clk_sync[1];
    assign data_s = dat_sync[1];
    assign flip_c = (clk_s != filt) && (fcnt == FCNT_W'(FILTER_LEN - 1));

    // Idle-high lines reset to 1 so release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            fcnt     <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            fall     <= flip_c && filt;
            if (clk_s == filt) begin
                fcnt <= '0;
            end else if (flip_c) begin
                filt <= clk_s;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            acc_q     <= 1'b0;
            perr_q    <= 1'b0;
            idle_q    <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            perr_q    <= perr_d;
            idle_q    <= idle_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
        end
    end

    // Frame decoder; the mid-frame idle counter aborts stalled frames.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        perr_d    = perr_q;
        idle_d    = '0;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        if (state_q != IDLE && !fall) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        acc_d     = 1'b0;
                    end
                end
                DATA: begin
                    sh_d      = {data_s, sh_q[BYTE_W-1:1]};
                    acc_d     = acc_q ^ data_s;
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) state_d = PAR;
                end
                PAR: begin
                    perr_d  = ~(acc_q ^ data_s);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s) push_d = 1'b1;
                    else        ferr_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_push = push_q && !(PARITY_DROP && perr_q);
    assign fifo_pop  = sel && !we && !addr;

    xps2_rx_fifo #(
        .DEPTH_LOG (FIFO_DEPTH_LOG),
        .W         (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (sh_q),
        .head_c  (fifo_head),
        .empty_c (fifo_empty),
        .full_c  (fifo_full),
        .drop_c  (fifo_drop),
        .count   (fifo_count)
    );

    // Sticky flags: write-1-to-clear, a same-cycle set takes priority.
    assign clr_c          = (sel && we && addr) ? data_in[2:0] : 3'b000;
    assign unused_data_in = ^{data_in[DATA_W-1:3], fifo_full};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_flag <= 1'b0;
            ferr_flag <= 1'b0;
            ovr_flag  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            perr_flag <= (perr_flag && !clr_c[ST_PERR]) || (push_q && perr_q);
            ferr_flag <= (ferr_flag && !clr_c[ST_FERR]) || ferr_q;
            ovr_flag  <= (ovr_flag  && !clr_c[ST_OVR])  || fifo_drop;
            irq       <= !fifo_empty;
        end
    end

    always_comb begin
        data_out = '0;
        if (sel && !we) begin
            if (!addr) begin
                data_out[DATA_VALID_BIT] = !fifo_empty;
                data_out[BYTE_W-1:0]     = fifo_empty ? '0 : fifo_head;
            end else begin
                data_out[ST_CNT_LSB +: FIFO_DEPTH_LOG + 1] = fifo_count;
                data_out[ST_OVR]  = ovr_flag;
                data_out[ST_FERR] = ferr_flag;
                data_out[ST_PERR] = perr_flag;
            end
        end
    end

endmodule
